// File: rtl/cla_adder.sv
// Registered two-level carry look-ahead adder: 4-bit groups with flattened
// carry equations, plus a second-level unit that forms every group carry-in.

module cla_group (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       pg,
  output logic       gg,
  output logic       msb_cin
);
  logic [3:0] p, g, c;

  assign p = a ^ b;
  assign g = a & b;

  // Each carry is a flat sum-of-products of the group carry-in.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);

  assign pg = &p;
  assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);

  assign s       = p ^ c;
  assign msb_cin = c[3];
endmodule

module cla_lookahead #(
  parameter int NG = 1
) (
  input  logic [NG-1:0] pg,
  input  logic [NG-1:0] gg,
  input  logic          cin,
  output logic [NG:0]   c,
  output logic          bp,
  output logic          bg
);
  logic [NG:0] gen, prop;

  // gen[k]/prop[k]: generate/propagate over groups 0..k-1, each a flat
  // product term so no group carry depends on another group's carry.
  always_comb begin
    logic term;
    gen  = '0;
    prop = '0;
    prop[0] = 1'b1;
    for (int k = 1; k <= NG; k++) begin
      prop[k] = 1'b1;
      for (int i = 0; i < NG; i++)
        if (i < k) prop[k] = prop[k] & pg[i];
      for (int j = 0; j < NG; j++) begin
        if (j < k) begin
          term = gg[j];
          for (int i = 0; i < NG; i++)
            if (i > j && i < k) term = term & pg[i];
          gen[k] = gen[k] | term;
        end
      end
    end
  end

  always_comb begin
    c = '0;
    for (int k = 0; k <= NG; k++) c[k] = gen[k] | (prop[k] & cin);
  end

  assign bp = prop[NG];
  assign bg = gen[NG];
endmodule

module cla_adder #(
  parameter int WIDTH = 4,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             P_out,
  output logic             G_out,
  output logic             ovf,
  output logic             out_valid
);
  localparam int NG = WIDTH / GROUP;

  logic [NG-1:0]      pg, gg, msb_cin;
  logic [NG:0]        gc;
  logic [WIDTH-1:0]   s_comb;
  logic               bp, bg;

  cla_lookahead #(.NG(NG)) u_la (
    .pg(pg), .gg(gg), .cin(Cin), .c(gc), .bp(bp), .bg(bg)
  );

  for (genvar n = 0; n < NG; n++) begin : g_grp
    cla_group u_grp (
      .a       (A[n*4 +: 4]),
      .b       (B[n*4 +: 4]),
      .cin     (gc[n]),
      .s       (s_comb[n*4 +: 4]),
      .pg      (pg[n]),
      .gg      (gg[n]),
      .msb_cin (msb_cin[n])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      S         <= '0;
      Cout      <= 1'b0;
      P_out     <= 1'b0;
      G_out     <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        S     <= s_comb;
        Cout  <= gc[NG];
        P_out <= bp;
        G_out <= bg;
        ovf   <= msb_cin[NG-1] ^ gc[NG];
      end
    end
  end
endmodule

// File: tb/tb_cla_adder.sv
// Self-checking bench: 4-bit and 16-bit adders against an arithmetic model.
module tb_cla_adder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, in_valid, cin;
  logic [3:0]  a4, b4, s4;
  logic [15:0] a16, b16, s16;
  logic        co4, p4, g4, ov4, v4;
  logic        co16, p16, g16, ov16, v16;

  cla_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .A(a4), .B(b4), .Cin(cin),
    .S(s4), .Cout(co4), .P_out(p4), .G_out(g4), .ovf(ov4), .out_valid(v4)
  );
  cla_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .A(a16), .B(b16), .Cin(cin),
    .S(s16), .Cout(co16), .P_out(p16), .G_out(g16), .ovf(ov16), .out_valid(v16)
  );

  int n_tests = 0, n_fail = 0;

  // model state
  logic [3:0]  m_s4;
  logic [15:0] m_s16;
  logic        m_c4, m_p4, m_g4, m_o4, m_c16, m_p16, m_g16, m_o16, m_v;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    logic [4:0]  t4, u4;
    logic [16:0] t16, u16;
    @(posedge clk);
    if (!rst_n) begin
      m_s4 = 0; m_c4 = 0; m_p4 = 0; m_g4 = 0; m_o4 = 0;
      m_s16 = 0; m_c16 = 0; m_p16 = 0; m_g16 = 0; m_o16 = 0;
    end else if (in_valid) begin
      t4  = {1'b0, a4} + {1'b0, b4} + {4'b0, cin};
      u4  = {1'b0, a4} + {1'b0, b4};
      m_s4 = t4[3:0]; m_c4 = t4[4]; m_g4 = u4[4];
      m_p4 = ((a4 ^ b4) == 4'hF);
      m_o4 = (a4[3] == b4[3]) && (t4[3] != a4[3]);
      t16 = {1'b0, a16} + {1'b0, b16} + {16'b0, cin};
      u16 = {1'b0, a16} + {1'b0, b16};
      m_s16 = t16[15:0]; m_c16 = t16[16]; m_g16 = u16[16];
      m_p16 = ((a16 ^ b16) == 16'hFFFF);
      m_o16 = (a16[15] == b16[15]) && (t16[15] != a16[15]);
    end
    m_v = rst_n & in_valid;
    #1;
    chk("s4", s4, m_s4);     chk("cout4", co4, m_c4); chk("p4", p4, m_p4);
    chk("g4", g4, m_g4);     chk("ovf4", ov4, m_o4);  chk("vld4", v4, m_v);
    chk("s16", s16, m_s16);  chk("cout16", co16, m_c16); chk("p16", p16, m_p16);
    chk("g16", g16, m_g16);  chk("ovf16", ov16, m_o16);  chk("vld16", v16, m_v);
  endtask

  task automatic set4(input logic [3:0] a, input logic [3:0] b, input logic c);
    a4 = a; b4 = b; cin = c;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b1; cin = 1'b1;
    a4 = 4'hF; b4 = 4'hF; a16 = 16'hFFFF; b16 = 16'hFFFF;

    // reset with operands presented
    repeat (2) begin
      cycle();
      chk("rst_s", s4, 4'h0); chk("rst_cout", co4, 1'b0); chk("rst_vld", v4, 1'b0);
    end
    rst_n = 1'b1;
    cycle();
    chk("rel_s", s4, 4'hF); chk("rel_cout", co4, 1'b1); chk("rel_vld", v4, 1'b1);

    // exhaustive 4-bit, streamed every cycle
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++) begin
          set4(4'(a), 4'(b), 1'(c));
          a16 = 16'($urandom); b16 = 16'($urandom);
          cycle();
        end

    set4(4'd0, 4'd0, 1'b1); cycle();
    chk("z1_s", s4, 4'd1); chk("z1_cout", co4, 1'b0);
    set4(4'd7, 4'd8, 1'b1); cycle();
    chk("prop_s", s4, 4'd0); chk("prop_cout", co4, 1'b1);
    chk("prop_p", p4, 1'b1); chk("prop_g", g4, 1'b0);
    set4(4'd15, 4'd15, 1'b1); cycle();
    chk("ones_s", s4, 4'd15); chk("ones_cout", co4, 1'b1); chk("ones_g", g4, 1'b1);
    set4(4'd7, 4'd8, 1'b0); cycle();
    chk("prop0_s", s4, 4'hF); chk("prop0_cout", co4, 1'b0);

    // signed overflow
    set4(4'h7, 4'h1, 1'b0); cycle();
    chk("ovf_pos_s", s4, 4'h8); chk("ovf_pos", ov4, 1'b1); chk("ovf_pos_cout", co4, 1'b0);
    set4(4'h8, 4'h8, 1'b0); cycle();
    chk("ovf_neg_s", s4, 4'h0); chk("ovf_neg", ov4, 1'b1); chk("ovf_neg_cout", co4, 1'b1);

    // hold when in_valid drops
    set4(4'd3, 4'd4, 1'b1); cycle();
    chk("hold_pre_s", s4, 4'd8);
    in_valid = 1'b0; set4(4'hF, 4'hF, 1'b0); cycle();
    chk("hold_s", s4, 4'd8); chk("hold_vld", v4, 1'b0);
    cycle();
    chk("hold2_s", s4, 4'd8);

    // mid-stream reset
    in_valid = 1'b1;
    set4(4'd5, 4'd6, 1'b0); cycle();
    set4(4'd9, 4'd9, 1'b1); rst_n = 1'b0; cycle();
    chk("mrst_s", s4, 4'd0); chk("mrst_cout", co4, 1'b0); chk("mrst_vld", v4, 1'b0);
    rst_n = 1'b1; cycle();
    chk("resume_s", s4, 4'd3); chk("resume_cout", co4, 1'b1);

    // 16-bit full propagate chain
    a16 = 16'hFFFF; b16 = 16'h0000; cin = 1'b1; cycle();
    chk("w16_s", s16, 16'h0000); chk("w16_cout", co16, 1'b1); chk("w16_p", p16, 1'b1);
    a16 = 16'hAAAA; b16 = 16'h5555; cin = 1'b0; cycle();
    chk("w16b_s", s16, 16'hFFFF); chk("w16b_cout", co16, 1'b0);

    // random stream with occasional idle cycles
    for (int i = 0; i < 10000; i++) begin
      in_valid = ($urandom_range(0, 7) != 0);
      a4 = 4'($urandom); b4 = 4'($urandom);
      a16 = 16'($urandom); b16 = 16'($urandom); cin = 1'($urandom);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/cla_adder.md
Name: cla_adder

Overview:
- Registered carry look-ahead adder: S = A + B + Cin, with carry-out, computed through two-level propagate/generate lookahead rather than ripple carry.
- Default 4-bit datapath; WIDTH scales in 4-bit groups, with a second-level lookahead unit spanning the groups.
- Serves as an arithmetic leaf in datapaths. Result registered once; single clock domain.

Parameters:
- WIDTH, 4, operand/sum width in bits; must be a multiple of 4, legal range 4..64.
- GROUP, 4, bits per first-level lookahead group; fixed at 4, and WIDTH % GROUP must equal 0.

Ports:
- clk  in  1  clock, rising-edge active
- rst_n  in  1  synchronous reset, active-low
- in_valid  in  1  operands valid this cycle
- A  in  WIDTH  operand A, unsigned
- B  in  WIDTH  operand B, unsigned
- Cin  in  1  carry-in
- S  out  WIDTH  registered sum, low WIDTH bits of A+B+Cin
- Cout  out  1  registered carry-out, bit WIDTH of A+B+Cin
- P_out  out  1  registered block propagate, AND of all p_i
- G_out  out  1  registered block generate; carry-out when Cin=0
- ovf  out  1  registered signed overflow, carry into MSB XOR Cout
- out_valid  out  1  registered copy of in_valid

Behaviour:
- Interface: one clock; reset is synchronous and active-low (clk, rst_n).
- Bit terms: p_i = A_i ^ B_i and g_i = A_i & B_i.
- Group carries: inside each 4-bit group, every carry is a flattened sum-of-products of g, p and the group carry-in:
  - c1 = g0 | p0·c0
  - c2 = g1 | p1·g0 | p1·p0·c0
  - c3 and c4 follow the same pattern.
- Group P/G:
  - PG = p3·p2·p1·p0
  - GG = g3 | p3·g2 | p3·p2·g1 | p3·p2·p1·g0
- Second-level lookahead: a unit takes the group PG/GG plus Cin and produces each group carry-in with the same flattened equations.
- Ripple is forbidden: no carry may ripple from one group to the next.
- Outputs:
  - S_i = p_i ^ c_i.
  - Cout = carry out of the top group.
  - P_out and G_out are the block-level propagate and generate.
- Latency: exactly 1 cycle from the in_valid edge to out_valid and registered results.
- Reset: if rst_n=0 at a rising edge, then S=0, Cout=0, P_out=0, G_out=0, ovf=0, out_valid=0. Reset has priority over in_valid.
- in_valid=1 at an edge (rst_n=1):
  - S, Cout, P_out, G_out and ovf load the new results.
  - out_valid becomes 1.
- in_valid=0 at an edge (rst_n=1):
  - S, Cout, P_out, G_out and ovf hold their previous values.
  - out_valid becomes 0.
- There is no backpressure. A new operand set may be accepted every cycle (throughput 1/cycle).
- Arithmetic: unsigned modulo 2^WIDTH; {Cout,S} == A+B+Cin exactly for all inputs.
- Boundaries:
  - All-ones plus all-ones plus Cin=1 gives S=all-ones, Cout=1.
  - A full propagate chain (A^B all ones) gives Cout=Cin and S=~Cin replicated.
- Reset mid-stream: a result captured in the same cycle as rst_n=0 is discarded.
- Inputs X/Z are not required to be handled.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with in_valid=1, A=4'hF, B=4'hF → S=0, Cout=0, out_valid=0. Release → the next edge gives S=4'hF, Cout=1.
- Exhaustive WIDTH=4: all A,B in 0..15, Cin in {0,1}, in_valid=1 each cycle. Each result one cycle later must match {Cout,S}=A+B+Cin; spot checks:
  - A=0,B=0,Cin=1 → S=1, Cout=0.
  - A=7,B=8,Cin=1 → S=0, Cout=1, P_out=1, G_out=0.
  - A=15,B=15,Cin=1 → S=15, Cout=1, G_out=1.
- Overflow (signed view): A=4'h7,B=4'h1,Cin=0 → S=4'h8, ovf=1, Cout=0. A=4'h8,B=4'h8,Cin=0 → S=0, ovf=1, Cout=1.
- Hold: after A=3,B=4,Cin=1 (S=8), drop in_valid and change A=15,B=15 → S stays 8, out_valid=0.
- Mid-stream reset: stream in_valid=1, then pulse rst_n=0 for one edge → all outputs 0 on that edge. Normal results resume on the next edge.
- WIDTH=16: A=16'hFFFF,B=16'h0000,Cin=1 → S=0, Cout=1, P_out=1. Random 10k vectors must match the reference sum.
